mcb_arb2: RTL and testbench

- Two-port round-robin arbiter that shares one MCB back-end command/data interface (bb/wr_n/bl/ba/ra/ca, busy, wdat_req, rdat_vld) between two requesters, e.g. the write-read-compare tester and a second host.
- Sits between the requesters and the MCB core, in the mcb_clk domain.
- Owns the MCB for one whole burst: command issue through the last data beat.
- Routes write-data requests and read data to the owning port, and aborts hung bursts with a watchdog.

---
 rtl/mcb_arb2.sv | 242 ++++++++++++++++++++++++
 tb/tb_mcb_arb2.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_arb2.sv
// Two-port round-robin arbiter sharing one MCB back-end command/data interface.
// The granted port owns the MCB from command issue until its last data beat, or until the watchdog aborts.
module mcb_arb2 #(
  parameter int DW  = 16,
  parameter int BAW = 2,
  parameter int RAW = 12,
  parameter int CAW = 8,
  parameter int TMO = 255
) (
  input  logic           mcb_clk,
  input  logic           mcb_rst_n,
  input  logic           p0_req,
  input  logic           p0_wr_n,
  input  logic [1:0]     p0_bl,
  input  logic [BAW-1:0] p0_ba,
  input  logic [RAW-1:0] p0_ra,
  input  logic [CAW-1:0] p0_ca,
  input  logic [DW-1:0]  p0_wdat,
  output logic           p0_ack,
  output logic           p0_wdat_req,
  output logic           p0_rdat_vld,
  output logic [DW-1:0]  p0_rdat,
  output logic           p0_done,
  input  logic           p1_req,
  input  logic           p1_wr_n,
  input  logic [1:0]     p1_bl,
  input  logic [BAW-1:0] p1_ba,
  input  logic [RAW-1:0] p1_ra,
  input  logic [CAW-1:0] p1_ca,
  input  logic [DW-1:0]  p1_wdat,
  output logic           p1_ack,
  output logic           p1_wdat_req,
  output logic           p1_rdat_vld,
  output logic [DW-1:0]  p1_rdat,
  output logic           p1_done,
  output logic           m_bb,
  output logic           m_wr_n,
  output logic [1:0]     m_bl,
  output logic [BAW-1:0] m_ba,
  output logic [RAW-1:0] m_ra,
  output logic [CAW-1:0] m_ca,
  output logic [DW-1:0]  m_wdat,
  input  logic           m_busy,
  input  logic           m_wdat_req,
  input  logic           m_rdat_vld,
  input  logic [DW-1:0]  m_rdat,
  output logic [1:0]     gnt,
  output logic           arb_err
);

  localparam int WDW = $clog2(TMO + 1);
  localparam logic [WDW-1:0] TMO_LAST = WDW'(TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic           last_gnt_r;
  logic [1:0]     gnt_r;
  logic [1:0]     done_r;
  logic           arb_err_r;
  logic           m_wr_n_r;
  logic [1:0]     m_bl_r;
  logic [BAW-1:0] m_ba_r;
  logic [RAW-1:0] m_ra_r;
  logic [CAW-1:0] m_ca_r;
  logic [3:0]     beat_cnt_r;
  logic [WDW-1:0] wdog_r;

  logic           any_req_s;
  logic           win_s;
  logic           sel_wr_n_s;
  logic [1:0]     sel_bl_s;
  logic [BAW-1:0] sel_ba_s;
  logic [RAW-1:0] sel_ra_s;
  logic [CAW-1:0] sel_ca_s;
  logic           is_wr_s;
  logic           accept_s;
  logic           beat_s;
  logic           last_beat_s;
  logic           abort_s;

  assign any_req_s   = p0_req | p1_req;
  assign is_wr_s     = ~m_wr_n_r;
  assign accept_s    = (state_r == ST_ISSUE) & ~m_busy;
  // Only the strobe matching the burst direction counts; the other one is ignored.
  assign beat_s      = (state_r == ST_XFER) & (is_wr_s ? m_wdat_req : m_rdat_vld);
  assign last_beat_s = beat_s & (beat_cnt_r == 4'd1);
  assign abort_s     = (state_r == ST_XFER) & ~beat_s & (wdog_r == TMO_LAST);

  // Winner selection: on contention the port that was not granted last wins.
  always_comb begin
    win_s = 1'b0;
    if (p0_req & p1_req) begin
      win_s = ~last_gnt_r;
    end else if (p1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      sel_wr_n_s = p1_wr_n;
      sel_bl_s   = p1_bl;
      sel_ba_s   = p1_ba;
      sel_ra_s   = p1_ra;
      sel_ca_s   = p1_ca;
    end else begin
      sel_wr_n_s = p0_wr_n;
      sel_bl_s   = p0_bl;
      sel_ba_s   = p0_ba;
      sel_ra_s   = p0_ra;
      sel_ca_s   = p0_ca;
    end
  end

  // FSM state register.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) state_nx_s = ST_ISSUE;
        else           state_nx_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (accept_s) state_nx_s = ST_XFER;
        else          state_nx_s = ST_ISSUE;
      end
      ST_XFER: begin
        if (last_beat_s | abort_s) state_nx_s = ST_IDLE;
        else                       state_nx_s = ST_XFER;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Grant, latched command fields, beat counter, watchdog, done and error flags.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      last_gnt_r <= 1'b1;
      gnt_r      <= 2'b00;
      done_r     <= 2'b00;
      arb_err_r  <= 1'b0;
      m_wr_n_r   <= 1'b1;
      m_bl_r     <= 2'b00;
      m_ba_r     <= '0;
      m_ra_r     <= '0;
      m_ca_r     <= '0;
      beat_cnt_r <= 4'd0;
      wdog_r     <= '0;
    end else begin
      done_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            gnt_r      <= win_s ? 2'b10 : 2'b01;
            last_gnt_r <= win_s;
            m_wr_n_r   <= sel_wr_n_s;
            m_bl_r     <= sel_bl_s;
            m_ba_r     <= sel_ba_s;
            m_ra_r     <= sel_ra_s;
            m_ca_r     <= sel_ca_s;
          end
        end
        ST_ISSUE: begin
          if (accept_s) begin
            beat_cnt_r <= 4'd1 << m_bl_r;
            wdog_r     <= '0;
          end
        end
        ST_XFER: begin
          if (last_beat_s) begin
            done_r <= gnt_r;
            gnt_r  <= 2'b00;
          end else if (abort_s) begin
            arb_err_r <= 1'b1;
            gnt_r     <= 2'b00;
          end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r - 4'd1;
            wdog_r     <= '0;
          end else begin
            wdog_r <= wdog_r + WDW'(1);
          end
        end
        default: gnt_r <= 2'b00;
      endcase
    end
  end

  // Command strobe, acceptance pulses and beat routing to the owner.
  always_comb begin
    m_bb        = 1'b0;
    p0_ack      = 1'b0;
    p1_ack      = 1'b0;
    p0_wdat_req = 1'b0;
    p1_wdat_req = 1'b0;
    p0_rdat_vld = 1'b0;
    p1_rdat_vld = 1'b0;
    m_wdat      = '0;
    case (state_r)
      ST_ISSUE: begin
        m_bb   = 1'b1;
        p0_ack = ~m_busy & gnt_r[0];
        p1_ack = ~m_busy & gnt_r[1];
      end
      ST_XFER: begin
        p0_wdat_req = m_wdat_req &  is_wr_s & gnt_r[0];
        p1_wdat_req = m_wdat_req &  is_wr_s & gnt_r[1];
        p0_rdat_vld = m_rdat_vld & ~is_wr_s & gnt_r[0];
        p1_rdat_vld = m_rdat_vld & ~is_wr_s & gnt_r[1];
        if (gnt_r[1]) m_wdat = p1_wdat;
        else          m_wdat = p0_wdat;
      end
      default: m_bb = 1'b0;
    endcase
  end

  assign m_wr_n  = m_wr_n_r;
  assign m_bl    = m_bl_r;
  assign m_ba    = m_ba_r;
  assign m_ra    = m_ra_r;
  assign m_ca    = m_ca_r;
  assign gnt     = gnt_r;
  assign p0_done = done_r[0];
  assign p1_done = done_r[1];
  assign arb_err = arb_err_r;
  assign p0_rdat = m_rdat;
  assign p1_rdat = m_rdat;

endmodule

// File: tb/tb_mcb_arb2.sv
// Scoreboard bench for mcb_arb2: directed bursts push expected events; a negedge monitor pops and compares.
module tb_mcb_arb2;

  localparam int DW  = 16;
  localparam int BAW = 2;
  localparam int RAW = 12;
  localparam int CAW = 8;
  localparam int TMO = 8;

  localparam logic [1:0] K_ACK  = 2'd0;
  localparam logic [1:0] K_RB   = 2'd1;
  localparam logic [1:0] K_WB   = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef logic [34:0] ev_t;  // {kind[1:0], port, data[31:0]}

  logic           mcb_clk = 1'b0;
  logic           mcb_rst_n;
  logic           p0_req, p0_wr_n, p1_req, p1_wr_n;
  logic [1:0]     p0_bl, p1_bl;
  logic [BAW-1:0] p0_ba, p1_ba;
  logic [RAW-1:0] p0_ra, p1_ra;
  logic [CAW-1:0] p0_ca, p1_ca;
  logic [DW-1:0]  p0_wdat, p1_wdat;
  logic           p0_ack, p0_wdat_req, p0_rdat_vld, p0_done;
  logic           p1_ack, p1_wdat_req, p1_rdat_vld, p1_done;
  logic [DW-1:0]  p0_rdat, p1_rdat;
  logic           m_bb, m_wr_n;
  logic [1:0]     m_bl;
  logic [BAW-1:0] m_ba;
  logic [RAW-1:0] m_ra;
  logic [CAW-1:0] m_ca;
  logic [DW-1:0]  m_wdat;
  logic           m_busy, m_wdat_req, m_rdat_vld;
  logic [DW-1:0]  m_rdat;
  logic [1:0]     gnt;
  logic           arb_err;

  ev_t sb_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  mcb_arb2 #(.DW(DW), .BAW(BAW), .RAW(RAW), .CAW(CAW), .TMO(TMO)) dut (
    .mcb_clk(mcb_clk), .mcb_rst_n(mcb_rst_n),
    .p0_req(p0_req), .p0_wr_n(p0_wr_n), .p0_bl(p0_bl), .p0_ba(p0_ba), .p0_ra(p0_ra),
    .p0_ca(p0_ca), .p0_wdat(p0_wdat), .p0_ack(p0_ack), .p0_wdat_req(p0_wdat_req),
    .p0_rdat_vld(p0_rdat_vld), .p0_rdat(p0_rdat), .p0_done(p0_done),
    .p1_req(p1_req), .p1_wr_n(p1_wr_n), .p1_bl(p1_bl), .p1_ba(p1_ba), .p1_ra(p1_ra),
    .p1_ca(p1_ca), .p1_wdat(p1_wdat), .p1_ack(p1_ack), .p1_wdat_req(p1_wdat_req),
    .p1_rdat_vld(p1_rdat_vld), .p1_rdat(p1_rdat), .p1_done(p1_done),
    .m_bb(m_bb), .m_wr_n(m_wr_n), .m_bl(m_bl), .m_ba(m_ba), .m_ra(m_ra), .m_ca(m_ca),
    .m_wdat(m_wdat), .m_busy(m_busy), .m_wdat_req(m_wdat_req), .m_rdat_vld(m_rdat_vld),
    .m_rdat(m_rdat), .gnt(gnt), .arb_err(arb_err)
  );

  always #5 mcb_clk = ~mcb_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic ev_t e_ack(input logic port, input logic wr_n, input logic [1:0] bl,
                                input logic [1:0] ba, input logic [11:0] ra, input logic [7:0] ca);
    logic [1:0] g;
    g = port ? 2'b10 : 2'b01;
    return {K_ACK, port, 4'h0, 1'b1, g, wr_n, bl, ba, ra, ca};
  endfunction

  function automatic ev_t e_beat(input logic [1:0] kind, input logic port, input logic [15:0] d);
    logic [1:0] g;
    g = port ? 2'b10 : 2'b01;
    return {kind, port, 14'h0, g, d};
  endfunction

  function automatic ev_t e_done(input logic port);
    return {K_DONE, port, 32'h0};
  endfunction

  task automatic observe(input logic [1:0] kind, input logic port, input logic [31:0] data);
    ev_t got;
    ev_t exp;
    got = {kind, port, data};
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL sb_spurious: actual=%h required=none", got);
    end else begin
      exp = sb_q.pop_front();
      check("sb_event", got, exp);
    end
  endtask

  // Monitor: every output event the DUT presents is matched against the scoreboard.
  always @(negedge mcb_clk) begin
    if (p0_ack === 1'b1) observe(K_ACK, 1'b0, {4'h0, m_bb, gnt, m_wr_n, m_bl, m_ba, m_ra, m_ca});
    if (p1_ack === 1'b1) observe(K_ACK, 1'b1, {4'h0, m_bb, gnt, m_wr_n, m_bl, m_ba, m_ra, m_ca});
    if (p0_rdat_vld === 1'b1) observe(K_RB, 1'b0, {14'h0, gnt, p0_rdat});
    if (p1_rdat_vld === 1'b1) observe(K_RB, 1'b1, {14'h0, gnt, p1_rdat});
    if (p0_wdat_req === 1'b1) observe(K_WB, 1'b0, {14'h0, gnt, m_wdat});
    if (p1_wdat_req === 1'b1) observe(K_WB, 1'b1, {14'h0, gnt, m_wdat});
    if (p0_done === 1'b1) observe(K_DONE, 1'b0, {30'h0, gnt});
    if (p1_done === 1'b1) observe(K_DONE, 1'b1, {30'h0, gnt});
  end

  task automatic tick();
    @(posedge mcb_clk);
    #1;
  endtask

  // Returns at the negedge of the cycle in which either ack is high.
  task automatic wait_ack();
    int  n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(negedge mcb_clk);
      if (p0_ack === 1'b1 || p1_ack === 1'b1) found = 1'b1;
      n++;
    end
    if (!found) begin
      total_cnt++;
      $display("FAIL ack_timeout: actual=no ack in %0d cycles required=ack", n);
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge mcb_clk);
    check({tag, "_gnt"},    gnt,      2'b00);
    check({tag, "_m_bb"},   m_bb,     1'b0);
    check({tag, "_m_wr_n"}, m_wr_n,   1'b1);
    check({tag, "_m_bl"},   m_bl,     2'b00);
    check({tag, "_m_addr"}, {m_ba, m_ra, m_ca}, 22'h0);
    check({tag, "_arb_err"}, arb_err, 1'b0);
    check({tag, "_done"},   {p0_done, p1_done}, 2'b00);
    check({tag, "_m_wdat"}, m_wdat,   16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    mcb_rst_n = 1'b0;
    p0_req = 1'b0; p0_wr_n = 1'b1; p0_bl = 2'b00; p0_ba = '0; p0_ra = '0; p0_ca = '0; p0_wdat = '0;
    p1_req = 1'b0; p1_wr_n = 1'b1; p1_bl = 2'b00; p1_ba = '0; p1_ra = '0; p1_ca = '0; p1_wdat = '0;
    m_busy = 1'b0; m_wdat_req = 1'b0; m_rdat_vld = 1'b0; m_rdat = '0;
    repeat (3) tick();
    check_reset_state("rst");

    // Single p0 read, 4 beats with gaps; done follows the 4th beat with gnt back at 00.
    tick();
    mcb_rst_n = 1'b1;
    sb_q.push_back(e_ack(1'b0, 1'b1, 2'b10, 2'd1, 12'h123, 8'h40));
    for (int i = 0; i < 4; i++) sb_q.push_back(e_beat(K_RB, 1'b0, 16'h1111 * 16'(i + 1)));
    sb_q.push_back(e_done(1'b0));
    p0_req = 1'b1; p0_wr_n = 1'b1; p0_bl = 2'b10; p0_ba = 2'd1; p0_ra = 12'h123; p0_ca = 8'h40;
    wait_ack();
    tick();
    p0_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rdat_vld = 1'b1; m_rdat = 16'h1111 * 16'(i + 1);
      tick();
      m_rdat_vld = 1'b0; m_rdat = 16'h0;
      tick();
    end

    // p1 read held off by m_busy for 10 ISSUE cycles.
    m_busy = 1'b1;
    sb_q.push_back(e_ack(1'b1, 1'b1, 2'b00, 2'd2, 12'hABC, 8'h11));
    sb_q.push_back(e_beat(K_RB, 1'b1, 16'hBEEF));
    sb_q.push_back(e_done(1'b1));
    p1_req = 1'b1; p1_wr_n = 1'b1; p1_bl = 2'b00; p1_ba = 2'd2; p1_ra = 12'hABC; p1_ca = 8'h11;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge mcb_clk);
      check("busy_hold", {m_bb, p1_ack, gnt}, {1'b1, 1'b0, 2'b10});
    end
    tick();
    m_busy = 1'b0;
    wait_ack();
    tick();
    p1_req = 1'b0;
    m_rdat_vld = 1'b1; m_rdat = 16'hBEEF;
    tick();
    m_rdat_vld = 1'b0;

    // Both ports write continuously: p1 was granted last, so p0,p1,p0,p1.
    p0_wr_n = 1'b0; p0_bl = 2'b00; p0_ba = 2'd0; p0_ra = 12'h010; p0_ca = 8'h01; p0_wdat = 16'hA5A5;
    p1_wr_n = 1'b0; p1_bl = 2'b00; p1_ba = 2'd3; p1_ra = 12'h020; p1_ca = 8'h02; p1_wdat = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        sb_q.push_back(e_ack(1'b0, 1'b0, 2'b00, 2'd0, 12'h010, 8'h01));
        sb_q.push_back(e_beat(K_WB, 1'b0, 16'hA5A5));
        sb_q.push_back(e_done(1'b0));
      end else begin
        sb_q.push_back(e_ack(1'b1, 1'b0, 2'b00, 2'd3, 12'h020, 8'h02));
        sb_q.push_back(e_beat(K_WB, 1'b1, 16'h5A5A));
        sb_q.push_back(e_done(1'b1));
      end
    end
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack();
      tick();
      if (i == 3) begin
        p0_req = 1'b0; p1_req = 1'b0;
      end
      m_wdat_req = 1'b1;
      tick();
      m_wdat_req = 1'b0;
    end
    tick();

    // Write bl=11 stalls after 3 beats: watchdog aborts after TMO silent cycles, no done.
    sb_q.push_back(e_ack(1'b0, 1'b0, 2'b11, 2'd1, 12'h3FF, 8'hF0));
    for (int i = 0; i < 3; i++) sb_q.push_back(e_beat(K_WB, 1'b0, 16'h1000 + 16'(i)));
    p0_req = 1'b1; p0_wr_n = 1'b0; p0_bl = 2'b11; p0_ba = 2'd1; p0_ra = 12'h3FF; p0_ca = 8'hF0;
    wait_ack();
    tick();
    p0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p0_wdat = 16'h1000 + 16'(i); m_wdat_req = 1'b1;
      tick();
    end
    m_wdat_req = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge mcb_clk);
      check("wdog_pending", {gnt, arb_err}, {2'b01, 1'b0});
      tick();
    end
    @(negedge mcb_clk);
    check("wdog_abort", {gnt, arb_err, p0_done}, {2'b00, 1'b1, 1'b0});

    // Next request after the abort is served normally; arb_err stays set.
    tick();
    sb_q.push_back(e_ack(1'b1, 1'b1, 2'b01, 2'd0, 12'h055, 8'h0A));
    sb_q.push_back(e_beat(K_RB, 1'b1, 16'hC0DE));
    sb_q.push_back(e_beat(K_RB, 1'b1, 16'hC0DF));
    sb_q.push_back(e_done(1'b1));
    p1_req = 1'b1; p1_wr_n = 1'b1; p1_bl = 2'b01; p1_ba = 2'd0; p1_ra = 12'h055; p1_ca = 8'h0A;
    wait_ack();
    tick();
    p1_req = 1'b0;
    m_rdat_vld = 1'b1; m_rdat = 16'hC0DE;
    tick();
    m_rdat = 16'hC0DF;
    tick();
    m_rdat_vld = 1'b0;
    @(negedge mcb_clk);
    check("err_sticky", arb_err, 1'b1);
    tick();

    // Stray m_rdat_vld in IDLE and during a write must not route nor count as beats.
    m_rdat_vld = 1'b1; m_rdat = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge mcb_clk);
      check("stray_idle", {p0_rdat_vld, p1_rdat_vld, gnt}, {1'b0, 1'b0, 2'b00});
      tick();
    end
    m_rdat_vld = 1'b0;
    sb_q.push_back(e_ack(1'b0, 1'b0, 2'b01, 2'd2, 12'h777, 8'h33));
    sb_q.push_back(e_beat(K_WB, 1'b0, 16'h2001));
    sb_q.push_back(e_beat(K_WB, 1'b0, 16'h2002));
    sb_q.push_back(e_done(1'b0));
    p0_req = 1'b1; p0_wr_n = 1'b0; p0_bl = 2'b01; p0_ba = 2'd2; p0_ra = 12'h777; p0_ca = 8'h33;
    wait_ack();
    tick();
    p0_req = 1'b0;
    m_rdat_vld = 1'b1;
    tick();
    m_rdat_vld = 1'b0; m_wdat_req = 1'b1; p0_wdat = 16'h2001;
    tick();
    m_wdat_req = 1'b0; m_rdat_vld = 1'b1;
    @(negedge mcb_clk);
    check("stray_xfer", {p0_rdat_vld, p1_rdat_vld, gnt}, {1'b0, 1'b0, 2'b01});
    tick();
    m_rdat_vld = 1'b0; m_wdat_req = 1'b1; p0_wdat = 16'h2002;
    tick();
    m_wdat_req = 1'b0;
    tick();

    // Reset mid-XFER: no done, everything back to reset values, p0 wins first again.
    sb_q.push_back(e_ack(1'b0, 1'b1, 2'b11, 2'd3, 12'h0F0, 8'h77));
    sb_q.push_back(e_beat(K_RB, 1'b0, 16'h0101));
    sb_q.push_back(e_beat(K_RB, 1'b0, 16'h0202));
    p0_req = 1'b1; p0_wr_n = 1'b1; p0_bl = 2'b11; p0_ba = 2'd3; p0_ra = 12'h0F0; p0_ca = 8'h77;
    wait_ack();
    tick();
    p0_req = 1'b0;
    m_rdat_vld = 1'b1; m_rdat = 16'h0101;
    tick();
    m_rdat = 16'h0202;
    tick();
    m_rdat_vld = 1'b0;
    mcb_rst_n = 1'b0;
    tick();
    mcb_rst_n = 1'b1;
    check_reset_state("midrst");
    tick();
    sb_q.push_back(e_ack(1'b0, 1'b1, 2'b00, 2'd1, 12'h00A, 8'h0B));
    sb_q.push_back(e_beat(K_RB, 1'b0, 16'h0A0A));
    sb_q.push_back(e_done(1'b0));
    sb_q.push_back(e_ack(1'b1, 1'b1, 2'b00, 2'd2, 12'h00C, 8'h0D));
    sb_q.push_back(e_beat(K_RB, 1'b1, 16'h0B0B));
    sb_q.push_back(e_done(1'b1));
    p0_req = 1'b1; p0_wr_n = 1'b1; p0_bl = 2'b00; p0_ba = 2'd1; p0_ra = 12'h00A; p0_ca = 8'h0B;
    p1_req = 1'b1; p1_wr_n = 1'b1; p1_bl = 2'b00; p1_ba = 2'd2; p1_ra = 12'h00C; p1_ca = 8'h0D;
    wait_ack();
    tick();
    p0_req = 1'b0;
    m_rdat_vld = 1'b1; m_rdat = 16'h0A0A;
    tick();
    m_rdat_vld = 1'b0;
    wait_ack();
    tick();
    p1_req = 1'b0;
    m_rdat_vld = 1'b1; m_rdat = 16'h0B0B;
    tick();
    m_rdat_vld = 1'b0;
    repeat (4) tick();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
